// File: rtl/keypad_scanner.sv
// keypad_scanner: rotating one-hot column strobe with a 2-FF row synchroniser,
// press/release debouncing and single-key / multi-key reporting.
module keypad_scanner #(
  parameter int N_COLS   = 4,
  parameter int N_ROWS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int CW = $clog2(N_COLS),
  localparam int RW = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_ROWS-1:0] filas,
  output logic [N_COLS-1:0] columnas,
  output logic              key_valid,
  output logic [CW-1:0]     key_col,
  output logic [RW-1:0]     key_row,
  output logic              key_held,
  output logic              key_release,
  output logic              key_multi
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]     DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0]     SETTLE_END = DW'(2);
  localparam logic [NW-1:0]     CNT_LAST   = NW'(DEBOUNCE - 1);
  localparam logic [NW-1:0]     CNT_ONE    = NW'(1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(N_COLS - 1);
  localparam logic [CW-1:0]     COL_ONE    = CW'(1);
  localparam logic [N_ROWS-1:0] ROW_ONE    = N_ROWS'(1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t            state, state_nxt;
  logic [N_ROWS-1:0] filas_p0, filas_s;
  logic [N_ROWS-1:0] pattern, pattern_nxt;
  logic [CW-1:0]     col_idx, col_nxt;
  logic [DW-1:0]     dwell, dwell_nxt;
  logic [NW-1:0]     cnt, cnt_nxt;
  logic              valid_nxt, release_nxt, multi_nxt, held_nxt;
  logic [CW-1:0]     key_col_nxt;
  logic [RW-1:0]     key_row_nxt;
  logic              press_done, rel_done;

  function automatic logic is_one_hot(input logic [N_ROWS-1:0] p);
    return (p != '0) && ((p & (p - ROW_ONE)) == '0);
  endfunction

  function automatic logic [RW-1:0] row_index(input logic [N_ROWS-1:0] p);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_ROWS; i++)
      if (p[i]) idx = RW'(i);
    return idx;
  endfunction

  function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
    return (c == COL_LAST) ? '0 : c + COL_ONE;
  endfunction

  // The DEBOUNCE-th matching (or zero) sample is the one taken while cnt sits at DEBOUNCE-1.
  assign press_done = (state == PRESS_DB) && (filas_s == pattern) && (cnt == CNT_LAST);
  assign rel_done   = (state == REL_DB) && (filas_s == '0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filas_p0    <= '0;
      filas_s     <= '0;
      state       <= SCAN;
      pattern     <= '0;
      col_idx     <= '0;
      dwell       <= '0;
      cnt         <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_multi   <= 1'b0;
      key_held    <= 1'b0;
      key_col     <= '0;
      key_row     <= '0;
    end else begin
      filas_p0    <= filas;
      filas_s     <= filas_p0;
      state       <= state_nxt;
      pattern     <= pattern_nxt;
      col_idx     <= col_nxt;
      dwell       <= dwell_nxt;
      cnt         <= cnt_nxt;
      key_valid   <= valid_nxt;
      key_release <= release_nxt;
      key_multi   <= multi_nxt;
      key_held    <= held_nxt;
      key_col     <= key_col_nxt;
      key_row     <= key_row_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    col_nxt     = col_idx;
    dwell_nxt   = dwell;
    cnt_nxt     = cnt;
    if (!enable) begin
      state_nxt = SCAN;
      col_nxt   = '0;
      dwell_nxt = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SCAN: begin
          // Dwell 0 and 1 only flush samples taken under the previous column.
          if (dwell >= SETTLE_END && filas_s != '0) begin
            pattern_nxt = filas_s;
            cnt_nxt     = CNT_ONE;
            state_nxt   = PRESS_DB;
          end else if (dwell == DWELL_LAST) begin
            dwell_nxt = '0;
            col_nxt   = next_col(col_idx);
          end else begin
            dwell_nxt = dwell + DWELL_ONE;
          end
        end
        PRESS_DB: begin
          if (filas_s != pattern) begin
            state_nxt = SCAN;
            dwell_nxt = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (filas_s == '0) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = REL_DB;
          end
        end
        REL_DB: begin
          if (filas_s != '0) begin
            state_nxt = HELD;
          end else if (cnt == CNT_LAST) begin
            state_nxt = SCAN;
            dwell_nxt = '0;
            col_nxt   = next_col(col_idx);
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    multi_nxt   = 1'b0;
    held_nxt    = key_held;
    key_col_nxt = key_col;
    key_row_nxt = key_row;
    if (!enable) begin
      held_nxt = 1'b0;
    end else if (press_done) begin
      if (is_one_hot(pattern)) begin
        valid_nxt   = 1'b1;
        key_col_nxt = col_idx;
        key_row_nxt = row_index(pattern);
        held_nxt    = 1'b1;
      end else begin
        multi_nxt = 1'b1;
      end
    end else if (rel_done) begin
      release_nxt = key_held;
      held_nxt    = 1'b0;
    end
  end

  always_comb begin
    columnas = '0;
    if (enable) columnas[col_idx] = 1'b1;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized presses, every
// output compared each cycle against a sample-counting reference model.
module tb_keypad_scanner;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int SD = 8;
  localparam int DB = 4;

  logic       clk, reset, enable;
  logic [3:0] filas, columnas;
  logic       key_valid, key_held, key_release, key_multi;
  logic [1:0] key_col, key_row;

  keypad_scanner #(.N_COLS(NC), .N_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .filas(filas), .columnas(columnas),
    .key_valid(key_valid), .key_col(key_col), .key_row(key_row), .key_held(key_held),
    .key_release(key_release), .key_multi(key_multi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp, n_err, cyc;
  int n_valid, n_release, n_multi, valid_cyc, release_cyc;
  int p, r;

  // Reference model: pin delay line, current column and its age, and run counts of samples.
  logic [3:0] msync0, msync1, cand;
  int         mcol, age, same, zeros;
  bit         frozen, accepted;
  logic       e_valid, e_release, e_multi, e_held;
  logic [1:0] e_col, e_row;

  task automatic model_reset();
    msync0 = '0; msync1 = '0; cand = '0;
    mcol = 0; age = 0; same = 0; zeros = 0;
    frozen = 0; accepted = 0;
    e_valid = 0; e_release = 0; e_multi = 0; e_held = 0;
    e_col = '0; e_row = '0;
  endtask

  task automatic model_step();
    logic [3:0] smp;
    if (!reset) begin
      model_reset();
      return;
    end
    smp = msync1;
    msync1 = msync0;
    msync0 = filas;
    e_valid = 0; e_release = 0; e_multi = 0;
    if (!enable) begin
      frozen = 0; accepted = 0; mcol = 0; age = 0; e_held = 0;
      return;
    end
    if (!frozen) begin
      if (age >= 2 && smp != 0) begin
        frozen = 1; accepted = 0; cand = smp; same = 1;
      end else if (age == SD - 1) begin
        age = 0;
        mcol = (mcol + 1) % NC;
      end else begin
        age++;
      end
    end else if (!accepted) begin
      if (smp != cand) begin
        frozen = 0;
        age = 0;
      end else begin
        same++;
        if (same == DB) begin
          accepted = 1;
          zeros = 0;
          if ($countones(cand) == 1) begin
            e_valid = 1;
            e_held = 1;
            e_col = 2'(mcol);
            for (int i = 0; i < NR; i++) if (cand[i]) e_row = 2'(i);
          end else begin
            e_multi = 1;
          end
        end
      end
    end else begin
      if (smp == 0) begin
        zeros++;
        if (zeros == DB) begin
          e_release = e_held;
          e_held = 0;
          frozen = 0;
          accepted = 0;
          age = 0;
          mcol = (mcol + 1) % NC;
        end
      end else begin
        zeros = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] ecols;
    ecols = enable ? 4'(1 << mcol) : 4'b0;
    chk("columnas", 32'(columnas), 32'(ecols));
    chk("key_valid", 32'(key_valid), 32'(e_valid));
    chk("key_release", 32'(key_release), 32'(e_release));
    chk("key_multi", 32'(key_multi), 32'(e_multi));
    chk("key_held", 32'(key_held), 32'(e_held));
    chk("key_col", 32'(key_col), 32'(e_col));
    chk("key_row", 32'(key_row), 32'(e_row));
    if (key_valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
    if (key_release === 1'b1) begin n_release++; release_cyc = cyc; end
    if (key_multi === 1'b1) n_multi++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    n_valid = 0; n_release = 0; n_multi = 0;
    valid_cyc = -1; release_cyc = -1;
  endtask

  // Advance until column c is strobed with a dwell that leaves room for the press.
  task automatic wait_col(input int c, input int dmax);
    bit found;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (!frozen && mcol == c && age <= dmax) found = 1;
      else tick();
    end
    chk("wait_col", 32'(found), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; filas = '0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all();
    tick(); tick();
    reset = 1'b1;

    // Idle scan: full rotation, no pulses.
    clr_counts();
    hold(40);
    chk("idle_pulses", 32'(n_valid + n_release + n_multi), 32'd0);

    // Row 2 in column 1, then clean release.
    clr_counts();
    wait_col(1, 5);
    p = cyc; filas = 4'b0100;
    hold(20);
    chk("press_cnt", 32'(n_valid), 32'd1);
    chk("press_lat", 32'(valid_cyc - p), 32'(DB + 2));
    chk("press_col", 32'(key_col), 32'd1);
    chk("press_row", 32'(key_row), 32'd2);
    r = cyc; filas = 4'b0000;
    hold(12);
    chk("rel_cnt", 32'(n_release), 32'd1);
    chk("rel_lat", 32'(release_cyc - r), 32'(DB + 2));

    // Bouncing contact on row 1 in column 2.
    clr_counts();
    wait_col(2, 3);
    filas = 4'b0010; tick();
    filas = 4'b0000; tick();
    filas = 4'b0010;
    hold(16);
    chk("bounce_cnt", 32'(n_valid), 32'd1);
    chk("bounce_row", 32'(key_row), 32'd1);
    filas = 4'b0000;
    hold(12);

    // Rows 0 and 3 together in column 0.
    clr_counts();
    wait_col(0, 5);
    filas = 4'b1001;
    hold(12);
    chk("multi_cnt", 32'(n_multi), 32'd1);
    chk("multi_valid", 32'(n_valid), 32'd0);
    chk("multi_held", 32'(key_held), 32'd0);
    chk("multi_col_kept", 32'(key_col), 32'd2);
    chk("multi_row_kept", 32'(key_row), 32'd1);
    filas = 4'b0000;
    hold(12);
    chk("multi_no_rel", 32'(n_release), 32'd0);
    chk("multi_next_col", 32'(columnas), 32'b0010);

    // Release with a one-cycle glitch at zero count 2.
    clr_counts();
    wait_col(3, 5);
    filas = 4'b1000;
    hold(10);
    filas = 4'b0000; tick(); tick();
    filas = 4'b1000; tick();
    r = cyc; filas = 4'b0000;
    hold(12);
    chk("glitch_rel_cnt", 32'(n_release), 32'd1);
    chk("glitch_rel_lat", 32'(release_cyc - r), 32'(DB + 2));

    // Asynchronous reset in the middle of press debouncing.
    wait_col(1, 3);
    filas = 4'b0100;
    hold(3);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_key_col", 32'(key_col), 32'd0);
    filas = 4'b0000;
    tick(); tick();
    reset = 1'b1;
    hold(10);

    // Enable dropped while a key is held.
    wait_col(2, 5);
    filas = 4'b0001;
    hold(10);
    chk("en_press_held", 32'(key_held), 32'd1);
    enable = 1'b0;
    clr_counts();
    tick();
    chk("en_off_cols", 32'(columnas), 32'd0);
    chk("en_off_held", 32'(key_held), 32'd0);
    filas = 4'b0000;
    hold(10);
    chk("en_off_pulses", 32'(n_valid + n_release + n_multi), 32'd0);
    chk("en_off_col_kept", 32'(key_col), 32'd2);
    enable = 1'b1;
    hold(10);

    // Randomized presses, bounces, roll-over patterns, glitches and enable drops.
    for (int ep = 0; ep < 40; ep++) begin
      logic [3:0] pat;
      int bounce, hl, gl;
      hold($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) pat = 4'($urandom_range(1, 15));
      else pat = 4'(1 << $urandom_range(0, 3));
      bounce = $urandom_range(0, 3);
      for (int b = 0; b < bounce; b++) begin
        filas = pat; tick();
        filas = 4'b0000; tick();
      end
      filas = pat;
      hl = $urandom_range(2, 14);
      if ($urandom_range(0, 7) == 0) begin
        hold(hl / 2);
        enable = 1'b0;
        hold(3);
        enable = 1'b1;
        hold(hl / 2);
      end else begin
        hold(hl);
      end
      filas = 4'b0000;
      gl = $urandom_range(0, 2);
      if (gl != 0) begin
        hold(gl);
        filas = pat; tick();
        filas = 4'b0000;
      end
      hold($urandom_range(6, 14));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
